counter_sequencer: RTL and testbench

//  Run controller for the free-running up-counter datapath: sequences bounded count runs.

---
 rtl/counter_sequencer.sv | 158 +++++++++++++++
 tb/tb_counter_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run controller for a bounded up-counter: start/stop/pause, one-shot or
// auto-reload runs, and a clock prescaler that sets the step period.
// P, tick and done come from registers. busy is decoded directly from the
// state register.
// Optional feature: define COUNT_SEQ_DOWN_EN to add a 'dir' input. The
// input is sampled on start, and dir=1 runs the count down from limit to 0.
module counter_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
`ifdef COUNT_SEQ_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  // Prescaler needs at least one bit even when PRESCALE == 1.
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PsW-1:0]   ps_q, ps_d;
  logic             reload_q, reload_d;
  logic             down_q, down_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             start_down;
  logic             accept;
  logic             active;
  logic             zero_run;
  logic             ps_wrap;
  logic             at_end;
  logic [WIDTH-1:0] p_step;
  logic [WIDTH-1:0] term;
  logic             finish;

`ifdef COUNT_SEQ_DOWN_EN
  assign start_down = dir;
`else
  assign start_down = 1'b0;
`endif

  // Run qualifiers. A step only happens on a busy, unstopped, unpaused edge
  // that also ends the prescaler period.
  assign accept   = (state_q == StIdle) && start && !stop;
  assign active   = (state_q != StIdle) && !stop && !pause;
  assign zero_run = (limit_q == '0);
  assign ps_wrap  = (ps_q == PsLast);
  // at_end marks the wrap point in auto-reload mode (limit going up, 0 going down).
  assign at_end   = down_q ? (p_q == '0) : (p_q == limit_q);
  assign p_step   = down_q ? (at_end ? limit_q : p_q - 1'b1)
                           : (at_end ? '0 : p_q + 1'b1);
  assign term     = down_q ? '0 : limit_q;
  assign finish   = active && !zero_run && ps_wrap && (p_step == term);

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      p_q      <= '0;
      limit_q  <= '0;
      ps_q     <= '0;
      reload_q <= 1'b0;
      down_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      limit_q  <= limit_d;
      ps_q     <= ps_d;
      reload_q <= reload_d;
      down_q   <= down_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  // Next-state selection: stop beats everything, pause parks the run in HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = pause ? StHold : StRun;
      end
      StRun, StHold: begin
        if (stop) begin
          state_d = StIdle;
        end else if (pause) begin
          state_d = StHold;
        end else if (zero_run) begin
          // A zero limit completes immediately; auto-reload is ignored.
          state_d = StIdle;
        end else if (finish && !reload_q) begin
          state_d = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values plus the registered tick/done pulses.
  always_comb begin
    p_d      = p_q;
    limit_d  = limit_q;
    ps_d     = ps_q;
    reload_d = reload_q;
    down_d   = down_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    if (accept) begin
      limit_d  = limit;
      reload_d = auto_reload;
      down_d   = start_down;
      p_d      = start_down ? limit : '0;
      ps_d     = '0;
    end else if (active) begin
      // Leaving HOLD also counts as a run edge, so each paused edge costs
      // exactly one cycle.
      if (zero_run) begin
        done_d = 1'b1;
      end else begin
        ps_d = ps_wrap ? '0 : ps_q + 1'b1;
        if (ps_wrap) begin
          p_d    = p_step;
          tick_d = 1'b1;
          done_d = (p_step == term);
        end
      end
    end
  end

  // Output decode.
  always_comb begin
    P    = p_q;
    busy = (state_q != StIdle);
    tick = tick_q;
    done = done_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer (WIDTH=4, PRESCALE=2).
// The reference model counts unpaused busy edges since the last start and
// derives the count and the pulses from that number with plain arithmetic.
module tb_counter_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned PS = 2;
`ifdef COUNT_SEQ_DOWN_EN
  localparam bit DownEn = 1'b1;
`else
  localparam bit DownEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] limit = '0;
  logic         auto_reload = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] P;
  logic         busy;
  logic         tick;
  logic         done;

  always #5 clk = ~clk;

  counter_sequencer #(
    .WIDTH    (W),
    .PRESCALE (PS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .limit       (limit),
    .auto_reload (auto_reload),
`ifdef COUNT_SEQ_DOWN_EN
    .dir         (dir),
`endif
    .P           (P),
    .busy        (busy),
    .tick        (tick),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int n_done   = 0;
  int n_tick   = 0;
  int last_done_edge = -1;

  // Reference model state.
  bit m_busy = 1'b0;
  int m_lim  = 0;
  bit m_rel  = 1'b0;
  bit m_dir  = 1'b0;
  int m_act  = 0;
  int m_p    = 0;
  bit m_tick = 1'b0;
  bit m_done = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Apply one clock edge to the model, using the inputs that the DUT just sampled.
  task automatic model_edge();
    int k;
    int pos;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_p = 0; m_lim = 0; m_rel = 1'b0; m_dir = 1'b0; m_act = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1'b1;
        m_lim  = int'(limit);
        m_rel  = auto_reload;
        m_dir  = dir;
        m_act  = 0;
        m_p    = dir ? m_lim : 0;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else if (!pause) begin
      m_act++;
      if (m_lim == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else if (m_act % int'(PS) == 0) begin
        k   = m_act / int'(PS);
        pos = m_rel ? k % (m_lim + 1) : k;
        m_p = m_dir ? m_lim - pos : pos;
        m_tick = 1'b1;
        if (pos == m_lim) begin
          m_done = 1'b1;
          if (!m_rel) m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit sp, input bit pa,
                       input int lim, input bit ar, input bit d);
    reset       = r;
    start       = s;
    stop        = sp;
    pause       = pa;
    limit       = lim[W-1:0];
    auto_reload = ar;
    dir         = DownEn && d;
    @(posedge clk);
    model_edge();
    edge_n++;
    @(negedge clk);
    check_eq("P", int'(P), m_p);
    check_eq("busy", int'(busy), int'(m_busy));
    check_eq("tick", int'(tick), int'(m_tick));
    check_eq("done", int'(done), int'(m_done));
    if (done) begin
      n_done++;
      last_done_edge = edge_n;
    end
    if (tick) n_tick++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_until_done(input int budget);
    int seen0;
    seen0 = n_done;
    for (int i = 0; i < budget && n_done == seen0; i++) idle(1);
    check_eq("done_seen", n_done - seen0, 1);
  endtask

  initial begin
    int s;
    int d0;
    int t0;

    // Reset state.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_eq("rst_P", int'(P), 0);
    check_eq("rst_busy", int'(busy), 0);

    // One-shot limit=3: P=1,2,3 at edges 2,4,6; done at 6.
    t0 = n_tick;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    s = edge_n;
    run_until_done(20);
    check_eq("os_lat", last_done_edge - s, 6);
    check_eq("os_P", int'(P), 3);
    check_eq("os_busy", int'(busy), 0);
    check_eq("os_ticks", n_tick - t0, 3);

    // Auto-reload limit=2: over 12 edges, 2 dones and 6 ticks, busy stays high.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    d0 = n_done;
    t0 = n_tick;
    idle(12);
    check_eq("ar_dones", n_done - d0, 2);
    check_eq("ar_ticks", n_tick - t0, 6);
    check_eq("ar_busy", int'(busy), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_eq("ar_stop_busy", int'(busy), 0);

    // Pause for 5 edges at P=1 delays the terminal done by exactly 5.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    s = edge_n;
    idle(2);
    check_eq("pz_P1", int'(P), 1);
    t0 = n_tick;
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check_eq("pz_frozen", int'(P), 1);
    check_eq("pz_noticks", n_tick - t0, 0);
    run_until_done(30);
    check_eq("pz_lat", last_done_edge - s, 11);

    // Stop at P=2: P holds, busy drops, no done.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    idle(4);
    check_eq("st_P2", int'(P), 2);
    d0 = n_done;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check_eq("st_busy", int'(busy), 0);
    check_eq("st_P", int'(P), 2);
    idle(3);
    check_eq("st_nodone", n_done - d0, 0);

    // limit=0: done one edge after start, no tick.
    t0 = n_tick;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    check_eq("z_busy", int'(busy), 1);
    idle(1);
    check_eq("z_done", int'(done), 1);
    check_eq("z_busy_end", int'(busy), 0);
    idle(2);
    check_eq("z_ticks", n_tick - t0, 0);

    // start while busy is ignored; run ends at the original limit.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    s = edge_n;
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
    run_until_done(30);
    check_eq("sb_lat", last_done_edge - s, 6);
    check_eq("sb_P", int'(P), 3);

    // Reset at P=2 clears everything and suppresses done.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    idle(4);
    check_eq("rr_P2", int'(P), 2);
    d0 = n_done;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_eq("rr_P", int'(P), 0);
    check_eq("rr_busy", int'(busy), 0);
    idle(8);
    check_eq("rr_nodone", n_done - d0, 0);

`ifdef COUNT_SEQ_DOWN_EN
    // Down count limit=3: P=3,2,1,0 every 2 cycles, done at 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    s = edge_n;
    check_eq("dn_P3", int'(P), 3);
    run_until_done(20);
    check_eq("dn_lat", last_done_edge - s, 6);
    check_eq("dn_P0", int'(P), 0);
    check_eq("dn_busy", int'(busy), 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
